// File: rtl/iobus_pkg.sv
// iobus_pkg: shared definitions for the I/O-window interconnect.
//   state_e      controller states (IDLE, WAIT, STAT, FAIL)
//   CAUSE_*      error cause codes recorded in the status word
//   STAT_*       bit positions inside the 32-bit status word
//   status_t     compact register image of the status word
//   status_word  expands status_t into the CPU-visible 32-bit word
package iobus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_STAT = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    localparam int STAT_VALID_BIT = 31;
    localparam int STAT_CAUSE_LSB = 29;
    localparam int STAT_WE_BIT    = 28;
    localparam int STAT_CNT_LSB   = 16;
    localparam int STAT_ADDR_LSB  = 0;

    typedef struct packed {
        logic       valid;
        logic [1:0] cause;
        logic       we;
        logic [7:0] cnt;
        logic [5:0] addr;
    } status_t;

    function automatic logic [31:0] status_word(input status_t s);
        logic [31:0] w;
        w = '0;
        w[STAT_VALID_BIT]        = s.valid;
        w[STAT_CAUSE_LSB +: 2]   = s.cause;
        w[STAT_WE_BIT]           = s.we;
        w[STAT_CNT_LSB +: 8]     = s.cnt;
        w[STAT_ADDR_LSB +: 6]    = s.addr;
        return w;
    endfunction

endpackage

// File: rtl/iobus_dec.sv
// iobus_dec: combinational decoder of a 6-bit I/O window word index.
//   addr_i      word index within the window
//   sel_o       one-hot channel select (lowest channel index wins overlaps)
//   hit_o       some channel matches (never set when addr_i is the status slot)
//   err_slot_o  addr_i is the status register slot
module iobus_dec
    import iobus_pkg::*;
#(
    parameter int                    CHAN_NUM  = 12,
    parameter logic [CHAN_NUM*6-1:0] CHAN_BASE = '0,
    parameter logic [CHAN_NUM-1:0]   CHAN_SPAN = '0,
    parameter logic [5:0]            ERR_SLOT  = 6'd46
) (
    input  logic [5:0]          addr_i,
    output logic [CHAN_NUM-1:0] sel_o,
    output logic                hit_o,
    output logic                err_slot_o
);

    always_comb begin
        sel_o      = '0;
        hit_o      = 1'b0;
        err_slot_o = (addr_i == ERR_SLOT);
        // Walk from the highest index down so the lowest matching channel is
        // the last one written and therefore wins.
        for (int i = CHAN_NUM - 1; i >= 0; i--) begin
            if (CHAN_SPAN[i] ? (addr_i[5:1] == CHAN_BASE[6*i+1 +: 5])
                             : (addr_i == CHAN_BASE[6*i +: 6])) begin
                sel_o    = '0;
                sel_o[i] = 1'b1;
                hit_o    = 1'b1;
            end
        end
        if (err_slot_o) begin
            sel_o = '0;
            hit_o = 1'b0;
        end
    end

endmodule

// File: rtl/iobus_ctrl.sv
// iobus_ctrl: I/O-window interconnect between the CPU bus and CHAN_NUM peripherals.
// Decodes the window into one-hot channel strobes, returns the selected channel's
// data/ack with no added latency, and guards against unmapped accesses and
// missing acks with a forced one-cycle ack plus a sticky error status register.
//   clk_i, rst_i        clock, asynchronous active-high reset
//   io_stb_i/we_i       CPU access strobe (held until ack) and write enable
//   io_addr_i/din_i     window word index, write data
//   io_dout_o/ack_o     read data and access-complete to the CPU
//   chan_stb_o          one-hot peripheral strobes
//   chan_dout_i/ack_i   peripheral read data (channel i at [32i+31:32i]) and acks
//   err_flag_o          sticky error present (status bit 31)
//   err_rst_o           one-cycle pulse on FAIL entry
// Build option: define IOBUS_ERR_RST_EN to enable err_rst_o; otherwise it is tied 0.
module iobus_ctrl
    import iobus_pkg::*;
#(
    parameter int                    CHAN_NUM    = 12,
    parameter logic [CHAN_NUM*6-1:0] CHAN_BASE   = {6'd11, 6'd10, 6'd9, 6'd8, 6'd7, 6'd6,
                                                    6'd5,  6'd4,  6'd3, 6'd2, 6'd1, 6'd0},
    parameter logic [CHAN_NUM-1:0]   CHAN_SPAN   = '0,
    parameter logic [5:0]            ERR_SLOT    = 6'd46,
    parameter int                    TIMEOUT_CYC = 1023
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     io_stb_i,
    input  logic                     io_we_i,
    input  logic [5:0]               io_addr_i,
    input  logic [31:0]              io_din_i,
    output logic [31:0]              io_dout_o,
    output logic                     io_ack_o,
    output logic [CHAN_NUM-1:0]      chan_stb_o,
    input  logic [32*CHAN_NUM-1:0]   chan_dout_i,
    input  logic [CHAN_NUM-1:0]      chan_ack_i,
    output logic                     err_flag_o,
    output logic                     err_rst_o
);

`ifdef IOBUS_ERR_RST_EN
    localparam logic ERR_RST_EN = 1'b1;
`else
    localparam logic ERR_RST_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    status_t            status_q, status_d;
    logic               err_rst_q;

    logic [CHAN_NUM-1:0] sel;
    logic                hit, err_slot;
    logic                chan_ack_sel;
    logic [31:0]         chan_dout_sel;
    logic                unmapped_evt, timeout_evt, stat_clr;
    logic                unused_din;

    // Any write to the status slot clears it; the data value carries no meaning.
    assign unused_din = ^io_din_i;

    iobus_dec #(
        .CHAN_NUM  (CHAN_NUM),
        .CHAN_BASE (CHAN_BASE),
        .CHAN_SPAN (CHAN_SPAN),
        .ERR_SLOT  (ERR_SLOT)
    ) u_dec (
        .addr_i     (io_addr_i),
        .sel_o      (sel),
        .hit_o      (hit),
        .err_slot_o (err_slot)
    );

    // sel is one-hot, so an AND-OR mux is enough.
    always_comb begin
        chan_ack_sel  = 1'b0;
        chan_dout_sel = '0;
        for (int i = 0; i < CHAN_NUM; i++) begin
            if (sel[i]) begin
                chan_ack_sel  = chan_ack_sel | chan_ack_i[i];
                chan_dout_sel = chan_dout_sel | chan_dout_i[32*i +: 32];
            end
        end
    end

    // The timer counts down from TIMEOUT_CYC-1 loaded on WAIT entry, so
    // reaching zero in WAIT is the TIMEOUT_CYC-th cycle after the strobe.
    assign unmapped_evt = (state_q == ST_IDLE) && io_stb_i && !hit && !err_slot;
    assign timeout_evt  = (state_q == ST_WAIT) && io_stb_i && !chan_ack_sel && (cnt_q == '0);
    assign stat_clr     = (state_q == ST_STAT) && io_stb_i && io_we_i;

    always_comb begin
        status_d = status_q;
        if (stat_clr) begin
            status_d = '0;
        end
        // An error recorded in the same cycle as a clear starts a fresh record.
        if (unmapped_evt || timeout_evt) begin
            if (status_d.valid) begin
                if (status_d.cnt != 8'hFF) begin
                    status_d.cnt = status_d.cnt + 8'd1;
                end
            end else begin
                status_d.valid = 1'b1;
                status_d.cause = unmapped_evt ? CAUSE_UNMAPPED : CAUSE_TIMEOUT;
                status_d.we    = io_we_i;
                status_d.cnt   = 8'd1;
                status_d.addr  = io_addr_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            status_q  <= '{valid: 1'b0, cause: CAUSE_NONE, we: 1'b0, cnt: 8'd0, addr: 6'd0};
            err_rst_q <= 1'b0;
        end else begin
            status_q  <= status_d;
            err_rst_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (io_stb_i) begin
                        if (err_slot) begin
                            state_q <= ST_STAT;
                        end else if (unmapped_evt) begin
                            state_q   <= ST_FAIL;
                            err_rst_q <= ERR_RST_EN;
                        end else if (!chan_ack_sel) begin
                            // A channel acking in the strobe cycle is already done.
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_W'(TIMEOUT_CYC - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!io_stb_i || chan_ack_sel) begin
                        state_q <= ST_IDLE;
                    end else if (timeout_evt) begin
                        state_q   <= ST_FAIL;
                        err_rst_q <= ERR_RST_EN;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        io_ack_o  = 1'b0;
        io_dout_o = '0;
        case (state_q)
            ST_STAT: begin
                io_ack_o  = 1'b1;
                io_dout_o = status_word(status_q);
            end
            ST_FAIL: io_ack_o = 1'b1;
            default: begin
                if (io_stb_i && hit) begin
                    io_ack_o  = chan_ack_sel;
                    io_dout_o = chan_dout_sel;
                end
            end
        endcase
    end

    assign chan_stb_o = (io_stb_i && state_q != ST_FAIL) ? sel : '0;
    assign err_flag_o = status_q.valid;
    assign err_rst_o  = err_rst_q;

endmodule

// File: tb/tb_iobus_ctrl.sv
// Testbench for iobus_ctrl: 3 channels at word 50/51 (ch0), 48 (ch1), 16 (ch2),
// status slot 46, timeout after 8 cycles. A transaction-level model predicts
// each cycle's outputs; one compare process checks them on the falling edge.
module tb_iobus_ctrl;

    localparam int TO = 8;
`ifdef IOBUS_ERR_RST_EN
    localparam bit RST_EN = 1'b1;
`else
    localparam bit RST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        io_stb = 1'b0, io_we = 1'b0;
    logic [5:0]  io_addr = '0;
    logic [31:0] io_din = '0;
    logic [31:0] io_dout;
    logic        io_ack;
    logic [2:0]  chan_stb;
    logic [95:0] chan_dout = '0;
    logic [2:0]  chan_ack = '0;
    logic        err_flag, err_rst;

    iobus_ctrl #(
        .CHAN_NUM    (3),
        .CHAN_BASE   ({6'd16, 6'd48, 6'd50}),
        .CHAN_SPAN   (3'b001),
        .ERR_SLOT    (6'd46),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .io_stb_i    (io_stb),
        .io_we_i     (io_we),
        .io_addr_i   (io_addr),
        .io_din_i    (io_din),
        .io_dout_o   (io_dout),
        .io_ack_o    (io_ack),
        .chan_stb_o  (chan_stb),
        .chan_dout_i (chan_dout),
        .chan_ack_i  (chan_ack),
        .err_flag_o  (err_flag),
        .err_rst_o   (err_rst)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Status model
    int m_valid = 0, m_cause = 0, m_we = 0, m_cnt = 0, m_addr = 0;

    function automatic logic [31:0] m_word();
        if (m_valid == 0) return 32'h0;
        return 32'h8000_0000 | (32'(m_cause) << 29) | (32'(m_we) << 28)
             | (32'(m_cnt) << 16) | 32'(m_addr);
    endfunction

    task automatic m_clear();
        m_valid = 0; m_cause = 0; m_we = 0; m_cnt = 0; m_addr = 0;
    endtask

    task automatic m_record(input int cause, input int we, input int addr);
        if (m_valid == 0) begin
            m_valid = 1; m_cause = cause; m_we = we; m_cnt = 1; m_addr = addr;
        end else if (m_cnt < 255) begin
            m_cnt++;
        end
    endtask

    // -2 status slot, -1 unmapped, else lowest matching channel
    function automatic int ref_target(input int a);
        int base [3] = '{50, 48, 16};
        int span [3] = '{1, 0, 0};
        if (a == 46) return -2;
        for (int c = 0; c < 3; c++) begin
            if (span[c] != 0 ? (a / 2 == base[c] / 2) : (a == base[c])) return c;
        end
        return -1;
    endfunction

    // Expectations for the current cycle
    bit          chk_en = 1'b0;
    logic        exp_ack = 1'b0, exp_flag = 1'b0, exp_rst = 1'b0, exp_dout_chk = 1'b0;
    logic [2:0]  exp_stb = '0;
    logic [31:0] exp_dout = '0;
    logic [31:0] last_dout = '0;
    logic [2:0]  last_stb = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("io_ack", 32'(io_ack), 32'(exp_ack));
            check("chan_stb", 32'(chan_stb), 32'(exp_stb));
            check("err_flag", 32'(err_flag), 32'(exp_flag));
            check("err_rst", 32'(err_rst), 32'(exp_rst));
            if (exp_dout_chk) check("io_dout", io_dout, exp_dout);
            if (exp_ack) begin
                last_dout = io_dout;
                last_stb  = chan_stb;
            end
        end
    end

    task automatic rand_periph();
        chan_ack  = 3'($urandom);
        chan_dout = {$urandom, $urandom, $urandom};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            io_stb = 1'b0; io_addr = 6'($urandom); io_we = 1'($urandom);
            rand_periph();
            exp_ack = 0; exp_stb = '0; exp_rst = 0; exp_dout_chk = 0;
            exp_flag = (m_valid != 0);
            @(posedge clk); #1;
        end
    endtask

    // d: cycle at which the target channel acks (> TO: never in time);
    // abort_at: cycle at which the CPU drops the strobe (0: no abort).
    task automatic txn(input int addr, input bit we, input int d, input int abort_at,
                       input logic [31:0] dval);
        int tgt, last;
        tgt = ref_target(addr);
        if (tgt < 0)      last = 1;
        else if (d <= TO) last = d;
        else              last = TO + 1;
        for (int k = 0; k <= last; k++) begin
            if (tgt >= 0 && abort_at > 0 && abort_at < last && k == abort_at) break;
            io_stb = 1'b1; io_addr = 6'(addr); io_we = we; io_din = $urandom;
            rand_periph();
            exp_ack = 0; exp_stb = '0; exp_rst = 0; exp_dout_chk = 0;
            if (tgt >= 0) begin
                chan_ack[tgt] = (k == d);
                chan_dout[32*tgt +: 32] = dval;
                if (k <= TO && k <= d) exp_stb = 3'(1 << tgt);
            end
            if (k == last) begin
                exp_ack = 1;
                exp_dout_chk = 1;
                if (tgt >= 0 && d <= TO) begin
                    exp_dout = dval;
                end else if (tgt == -2) begin
                    exp_dout = m_word();
                    exp_dout_chk = !we;
                end else begin
                    exp_dout = 32'h0;
                    m_record(tgt == -1 ? 1 : 2, int'(we), addr);
                    exp_rst = RST_EN;
                end
            end
            exp_flag = (m_valid != 0);
            @(posedge clk); #1;
            if (k == last && tgt == -2 && we) m_clear();
        end
        idle(1 + $urandom_range(0, 1));
    endtask

    function automatic int rand_unmapped();
        int a;
        a = $urandom_range(0, 63);
        while (ref_target(a) != -1) a = $urandom_range(0, 63);
        return a;
    endfunction

    initial begin
        int addr, d, ab, r;
        int pick [4] = '{50, 51, 48, 16};
        #1 rst = 1'b1;
        #1;
        check("reset_ack", 32'(io_ack), 32'h0);
        check("reset_dout", io_dout, 32'h0);
        check("reset_flag", 32'(err_flag), 32'h0);
        check("reset_errrst", 32'(err_rst), 32'h0);
        check("reset_stb", 32'(chan_stb), 32'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        idle(2);

        // 1: ch0 via span address 51, ack in strobe cycle
        txn(51, 0, 0, 0, 32'hA5);
        check("t1_dout_lit", last_dout, 32'hA5);
        check("t1_stb_lit", 32'(last_stb), 32'h1);
        // 2: unmapped read at 20
        txn(20, 0, 0, 0, 32'h0);
        txn(46, 0, 0, 0, 32'h0);
        check("t2_status_lit", last_dout, 32'hA001_0014);
        txn(46, 1, 0, 0, 32'h0);
        // 3: write to ch2, never acked
        txn(16, 1, 99, 0, $urandom);
        txn(46, 0, 0, 0, 32'h0);
        check("t3_status_lit", last_dout, 32'hD001_0010);
        // 4: ch1 acks on the last allowed cycle
        txn(48, 0, TO, 0, 32'h1234_5678);
        check("t4_dout_lit", last_dout, 32'h1234_5678);
        txn(46, 0, 0, 0, 32'h0);
        check("t4_status_lit", last_dout, 32'hD001_0010);
        txn(46, 1, 0, 0, 32'h0);
        txn(46, 0, 0, 0, 32'h0);
        check("t4_clear_lit", last_dout, 32'h0);
        // 5: 300 unmapped accesses, first at 20 (read)
        txn(20, 0, 0, 0, 32'h0);
        for (int i = 1; i < 300; i++) txn(rand_unmapped(), 1'($urandom), 0, 0, 32'h0);
        txn(46, 0, 0, 0, 32'h0);
        check("t5_status_lit", last_dout, 32'hA0FF_0014);

        // 6: asynchronous reset in the middle of a WAIT
        chk_en = 1'b0;
        check("t6_pre_flag", 32'(err_flag), 32'h1);
        io_stb = 1'b1; io_addr = 6'd16; io_we = 1'b0; chan_ack = '0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1; io_stb = 1'b0;
        #1;
        check("t6_rst_ack", 32'(io_ack), 32'h0);
        check("t6_rst_flag", 32'(err_flag), 32'h0);
        check("t6_rst_dout", io_dout, 32'h0);
        check("t6_rst_stb", 32'(chan_stb), 32'h0);
        @(negedge clk); rst = 1'b0;
        m_clear();
        @(posedge clk); #1;
        chk_en = 1'b1;
        txn(46, 0, 0, 0, 32'h0);
        check("t6_status_lit", last_dout, 32'h0);
        txn(50, 0, 2, 0, 32'hCAFE_F00D);
        check("t6_dout_lit", last_dout, 32'hCAFE_F00D);

        // Randomized traffic
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      addr = 46;
            else if (r < 6) addr = pick[$urandom_range(0, 3)];
            else            addr = $urandom_range(0, 63);
            d  = ($urandom_range(0, 9) < 3) ? 99 : $urandom_range(0, TO + 2);
            ab = ($urandom_range(0, 9) < 2) ? $urandom_range(1, TO) : 0;
            txn(addr, 1'($urandom), d, ab, $urandom);
        end
        idle(2);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
